// File: rtl/iter_seq_ctrl.sv
// Iteration sequencer: runs an external engine for a programmable number of passes
// (start, wait for done, write result, shift), with an engine timeout and abort.
module iter_seq_ctrl #(
    parameter int CW       = 4,
    parameter int DEF_ITER = 8,
    parameter int TO_W     = 8,
    parameter int TIMEOUT  = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] iter_n,
    input  logic          eng_done,
    output logic          done,
    output logic          busy,
    output logic          clr,
    output logic          ld,
    output logic          ui_reg_ld,
    output logic          eng_start,
    output logic          wr_reg,
    output logic          sh_en,
    output logic [CW-1:0] idx,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_SHIFT = 3'd6
    } state_t;

    localparam logic [CW-1:0]   DEF_LIMIT = CW'(DEF_ITER);
    localparam logic [TO_W-1:0] TMO_LAST  = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   limit_q, limit_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] tmo_q, tmo_d;

    // NOTE: async reset covers every flop; there is no memory array here to exclude.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            limit_q <= DEF_LIMIT;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            limit_q <= limit_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        limit_d   = limit_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        done      = 1'b0;
        clr       = 1'b0;
        ld        = 1'b0;
        ui_reg_ld = 1'b0;
        eng_start = 1'b0;
        wr_reg    = 1'b0;
        sh_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                done = 1'b1;
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                clr     = 1'b1;
                idx_d   = '0;
                err_d   = 1'b0;
                limit_d = (iter_n == '0) ? DEF_LIMIT : iter_n;
                if (!start) state_d = S_LOAD;
            end
            S_LOAD: begin
                ld        = 1'b1;
                ui_reg_ld = 1'b1;
                state_d   = S_START;
            end
            S_START: begin
                eng_start = 1'b1;
                tmo_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_d = S_WRITE;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                    if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                wr_reg = 1'b1;
                if (idx_q == limit_q - CW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + CW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_en   = 1'b1;
                state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes all bookkeeping so idx/err reflect the point of cancellation.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            limit_d = limit_q;
            err_d   = err_q;
            tmo_d   = tmo_q;
        end
    end

    assign busy = ~done;
    assign idx  = idx_q;
    assign err  = err_q;

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Directed bench for iter_seq_ctrl: reset, default/programmed runs, timeout,
// abort, simultaneous events and mid-run reset.
module tb_iter_seq_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] iter_n = '0;
    logic          eng_done;
    logic          done, busy, clr, ld, ui_reg_ld, eng_start, wr_reg, sh_en, err;
    logic [CW-1:0] idx;

    iter_seq_ctrl #(.CW(CW), .DEF_ITER(8), .TO_W(8), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iter_n(iter_n),
        .eng_done(eng_done), .done(done), .busy(busy), .clr(clr), .ld(ld),
        .ui_reg_ld(ui_reg_ld), .eng_start(eng_start), .wr_reg(wr_reg),
        .sh_en(sh_en), .idx(idx), .err(err)
    );

    always #5 clk = ~clk;

    // Engine model: either a tied level, or a done pulse eng_dly cycles after eng_start.
    logic eng_auto = 1'b0;
    logic eng_tie  = 1'b0;
    int   eng_dly  = 5;
    int   eng_cnt  = 0;
    always @(posedge clk) begin
        if (eng_start)        eng_cnt <= eng_dly;
        else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    end
    assign eng_done = eng_auto ? (eng_cnt == 1) : eng_tie;

    // Strobe counters sampled mid-cycle.
    int n_clr = 0, n_start = 0, n_wr = 0, n_sh = 0;
    logic [CW-1:0] wr_idx_log[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (clr)       n_clr++;
            if (eng_start) n_start++;
            if (sh_en)     n_sh++;
            if (wr_reg) begin
                n_wr++;
                wr_idx_log.push_back(idx);
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int b_clr, b_start, b_wr, b_sh, b_log;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();
        check("rst_done", done, 1);
        check("rst_busy", busy, 0);
        check("rst_idx", idx, 0);
        check("rst_err", err, 0);
        check("rst_strobes", {clr, ld, ui_reg_ld, eng_start, wr_reg, sh_en}, 0);

        // Default run: iter_n=0 -> 8 passes, engine always done
        iter_n = 0; eng_auto = 0; eng_tie = 1;
        b_clr = n_clr; b_start = n_start; b_wr = n_wr; b_sh = n_sh;
        start = 1;
        repeat (3) step();
        start = 0;
        step();
        check("def_load_ld", ld, 1);
        check("def_load_ui", ui_reg_ld, 1);
        check("def_clr_cycles", n_clr - b_clr, 3);
        run_until_done(cyc);
        check("def_latency", cyc, 32);
        check("def_eng_start", n_start - b_start, 8);
        check("def_wr_reg", n_wr - b_wr, 8);
        check("def_sh_en", n_sh - b_sh, 7);
        check("def_idx", idx, 7);
        check("def_err", err, 0);

        // Programmed run, slow engine
        iter_n = 3; eng_auto = 1; eng_dly = 5;
        b_wr = n_wr; b_sh = n_sh; b_log = wr_idx_log.size();
        start = 1; step();
        start = 0; step();
        run_until_done(cyc);
        check("slow_latency", cyc, 24);
        check("slow_wr_reg", n_wr - b_wr, 3);
        check("slow_sh_en", n_sh - b_sh, 2);
        check("slow_log_len", wr_idx_log.size() - b_log, 3);
        for (int k = 0; k < 3; k++)
            if (b_log + k < wr_idx_log.size())
                check($sformatf("slow_idx%0d", k), wr_idx_log[b_log + k], k);
        check("slow_idx_final", idx, 2);
        check("slow_err", err, 0);

        // Timeout: engine never responds
        iter_n = 1; eng_auto = 0; eng_tie = 0;
        b_wr = n_wr;
        start = 1; step();
        start = 0; step();
        run_until_done(cyc);
        check("tmo_latency", cyc, 12);
        check("tmo_err", err, 1);
        check("tmo_no_wr", n_wr - b_wr, 0);

        // Next start clears err in ARM; eng_done on final timeout cycle wins
        start = 1; step();
        check("arm_err_held", err, 1);
        start = 0; step();
        check("arm_err_clr", err, 0);
        step();
        check("race_eng_start", eng_start, 1);
        step();
        repeat (9) step();
        check("race_still_busy", done, 0);
        eng_tie = 1; step();
        check("race_wr_reg", wr_reg, 1);
        eng_tie = 0; step();
        check("race_done", done, 1);
        check("race_err", err, 0);

        // Abort in 2nd WAIT, together with eng_done
        iter_n = 5; eng_tie = 1;
        start = 1; step();
        start = 0; step();
        repeat (6) step();
        b_start = n_start; b_wr = n_wr; b_sh = n_sh;
        abort = 1; step();
        abort = 0;
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_idx", idx, 1);
        check("abort_err", err, 0);
        repeat (3) step();
        check("abort_no_wr", n_wr - b_wr, 0);
        check("abort_no_start", n_start - b_start, 0);
        check("abort_no_sh", n_sh - b_sh, 0);

        // Abort while idle is ignored; start still honoured afterwards
        abort = 1; step();
        abort = 0;
        check("idle_abort_done", done, 1);

        // Mid-run asynchronous reset
        start = 1; step();
        start = 0; step();
        step();
        #2 rst = 1;
        #1;
        check("mid_rst_done", done, 1);
        check("mid_rst_idx", idx, 0);
        check("mid_rst_start", eng_start, 0);
        @(negedge clk) rst = 0;
        step();
        check("post_rst_done", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
